demux_1_n_stream_v: RTL

DEMUX_1_N_STREAM_V -- requirements
Module: demux_1_n_stream_v

---
 rtl/demux_1_n_stream_v.sv | 89 ++++++++
 1 files changed

// File: rtl/demux_1_n_stream_v.sv
// One-to-N stream demultiplexer: each channel owns a one-entry output register,
// so a stalled channel blocks only words addressed to it and broadcasts.
module demux_1_n_stream_v #(
   parameter int DATA_W = 8,
   parameter int N_CH   = 4,
   localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_valid,
   output logic                     o_ready,
   input  logic [DATA_W-1:0]        i_data,
   input  logic [SEL_W-1:0]         i_sel,
   input  logic                     i_bcast,
   output logic [N_CH-1:0]          o_valid,
   input  logic [N_CH-1:0]          i_ready,
   output logic [N_CH*DATA_W-1:0]   o_data,
   output logic                     o_err
);

   logic [N_CH-1:0]        valid_q, valid_d;
   logic [N_CH*DATA_W-1:0] data_q, data_d;
   logic                   err_q, err_d;

   logic [N_CH-1:0]        can_take;
   logic [N_CH-1:0]        sel_oh;
   logic [N_CH-1:0]        load;
   logic                   sel_ok;
   logic                   xfer;

   // An out-of-range select decodes to an all-zero one-hot, which doubles as
   // the range check and keeps every index inside the channel vector.
   always_comb begin
      sel_oh = '0;
      for (int c = 0; c < N_CH; c++) begin
         sel_oh[c] = (i_sel == SEL_W'(c));
      end
   end

   assign sel_ok   = |sel_oh;
   assign can_take = ~valid_q | i_ready;

   always_comb begin
      o_ready = 1'b1;
      if (i_bcast) begin
         o_ready = &can_take;
      end else if (sel_ok) begin
         o_ready = |(sel_oh & can_take);
      end
   end

   assign xfer = i_valid & o_ready;

   always_comb begin
      load = '0;
      if (xfer) begin
         load = i_bcast ? {N_CH{1'b1}} : sel_oh;
      end
   end

   // A load wins over a simultaneous drain, giving one word per cycle per channel.
   always_comb begin
      valid_d = load | (valid_q & ~i_ready);
      data_d  = data_q;
      for (int c = 0; c < N_CH; c++) begin
         if (load[c]) begin
            data_d[c*DATA_W +: DATA_W] = i_data;
         end
      end
      err_d = xfer & ~i_bcast & ~sel_ok;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         valid_q <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         err_q   <= err_d;
      end
   end

   assign o_valid = valid_q;
   assign o_data  = data_q;
   assign o_err   = err_q;

endmodule
